gpio_in_cond: RTL and testbench
===============================

# gpio_in_cond

Input conditioner sitting directly upstream of the AHB GPIO peripheral. It takes raw, asynchronous pad inputs and produces the peripheral's `GPIOIN` bus. Each bit is synchronised into `HCLK` and debounced, and a parity bit is appended according to the same `PARITYSEL` the peripheral checks. A `FORCE_ERR` control corrupts that parity bit on demand, so the peripheral's `PARITYERR` path can be exercised.

## Interface
- `WIDTH`, 16, number of data bits; `GPIOIN` is `WIDTH+1` bits wide.
- `SYNC_STAGES`, 2, flip-flop stages in each bit's synchroniser; minimum 2.
- `DEBOUNCE_CYCLES`, 4, consecutive cycles a synchronised change must persist before it is accepted; minimum 1.
- `HCLK`  in  1  single clock for the block.
- `HRESET`  in  1  reset, synchronous and active-high.
- `PAD_IN`  in  WIDTH  raw, asynchronous pad inputs.
- `PARITYSEL`  in  1  parity mode: 1 = odd, 0 = even. Same meaning as at the GPIO peripheral.
- `FORCE_ERR`  in  1  when 1, the emitted parity bit is inverted (error injection).
- `GPIOIN`  out  WIDTH+1  `[WIDTH-1:0]` = debounced data, `[WIDTH]` = parity bit. Registered.
- `CHANGED`  out  1  one-cycle pulse when any debounced bit updates. Registered.

## Operation
- Synchroniser: each `PAD_IN[i]` passes through `SYNC_STAGES` flip-flops. The last stage is `sync[i]`.
- Debouncer, one per bit, holding `stable[i]` and `cnt[i]`. Counter width is `$clog2(DEBOUNCE_CYCLES)+1`. At each clock edge:
  - if `sync[i] == stable[i]`: `cnt[i] <= 0`.
  - else if `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= sync[i]`, `cnt[i] <= 0`.
  - else: `cnt[i] <= cnt[i]+1`.
- Any cycle where `sync` returns to `stable` before acceptance restarts that bit's count. Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles never reach `GPIOIN`.
- Bits are fully independent; several bits may be accepted on the same edge.
- Parity, computed from the next value of `stable` and registered with it:
  - even mode: `p = ^stable_next`.
  - odd mode: `p = ~^stable_next`.
  - Result: the `WIDTH+1`-bit word has an odd (odd mode) or even (even mode) number of ones.
  - `GPIOIN[WIDTH] <= p ^ FORCE_ERR`.
- `CHANGED <= 1` on any edge where at least one `stable[i]` changes; otherwise 0.
- No state machine beyond the per-bit counters. Counters never exceed `DEBOUNCE_CYCLES-1`, so there is no wrap.

## Timing
- Reset (`HRESET` high at an edge):
  - all synchroniser flops, `stable` and `cnt` go to 0.
  - `GPIOIN[WIDTH-1:0] = 0`.
  - `GPIOIN[WIDTH] = PARITYSEL ^ FORCE_ERR`, using values sampled at that edge.
  - `CHANGED = 0`.
- Reset mid-debounce discards pending counts. After release, a pad held at 1 is accepted after the full latency.
- Pad-to-`GPIOIN` latency: a change sampled at edge k appears at `GPIOIN` after edge `k + SYNC_STAGES + DEBOUNCE_CYCLES - 1`. With defaults, a change first sampled at edge 0 shows up after edge 5, i.e. 6 edges inclusive. `CHANGED` pulses for exactly that one cycle.
- `DEBOUNCE_CYCLES = 1`: a change is accepted on the first edge after it reaches `sync`.
- `PARITYSEL` or `FORCE_ERR` change: `GPIOIN[WIDTH]` updates on the next edge. Data bits are unaffected, and `CHANGED` does not pulse.
- Simultaneous data acceptance and a `PARITYSEL` change on the same edge: the parity bit reflects both the new data and the new mode.
- Pad toggling every cycle indefinitely: `stable` never changes and no `CHANGED` pulse occurs.

## Test plan
- Reset with `PARITYSEL=1`, `FORCE_ERR=0`, `PAD_IN=0` -> `GPIOIN=17'h10000`, `CHANGED=0`. Repeat with `PARITYSEL=0` -> `GPIOIN=17'h00000`.
- `PAD_IN` 0 -> `16'h0001` at edge 0, held (defaults, odd mode) -> `GPIOIN=17'h00001` after edge 5, with `CHANGED` high for one cycle. Nothing changes earlier.
- `PAD_IN[3]` glitch high for 3 cycles, then low -> `GPIOIN` stays `17'h10000` and `CHANGED` never asserts. The same glitch held for 4 cycles is accepted.
- `PAD_IN=16'hA5A5` applied at once, odd mode -> `GPIOIN=17'h1A5A5` (eight ones, so the parity bit is 1). A single `CHANGED` pulse.
- With data `16'h0003` stable:
  - toggle `PARITYSEL` 1 -> 0 -> `GPIOIN[16]` goes 1 -> 0 one edge later.
  - then `FORCE_ERR=1` -> `GPIOIN[16]=1`, and the downstream GPIO reports `PARITYERR`.
- `HRESET` asserted 2 cycles after a pad change (mid-debounce), then released with the pad held -> `GPIOIN` reads the reset value until the full latency has elapsed after release, then shows the new data.

Source files
------------

// File: rtl/gpio_in_cond.sv
// Pad input conditioner for the GPIO peripheral: per-bit synchroniser and debouncer,
// plus a parity bit (odd/even per PARITYSEL) that can be deliberately corrupted.
module gpio_in_cond #(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic [WIDTH-1:0] PAD_IN,
   input  logic             PARITYSEL,
   input  logic             FORCE_ERR,
   output logic [WIDTH:0]   GPIOIN,
   output logic             CHANGED
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]                  stable_q, stable_d;
   logic [WIDTH:0]                    gpioin_q, gpioin_d;
   logic                              changed_q, changed_d;
   logic [WIDTH-1:0]                  sync_last;
   logic                              parity;

   assign sync_last = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d    = sync_q;
      cnt_d     = cnt_q;
      stable_d  = stable_q;
      gpioin_d  = gpioin_q;
      changed_d = 1'b0;
      parity    = 1'b0;

      sync_d[0] = PAD_IN;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end

      // Any cycle where the input agrees with the accepted value restarts the count.
      for (int i = 0; i < WIDTH; i++) begin
         if (sync_last[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            stable_d[i] = sync_last[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end

      parity    = PARITYSEL ? ~^stable_d : ^stable_d;
      gpioin_d  = {parity ^ FORCE_ERR, stable_d};
      changed_d = |(stable_d ^ stable_q);
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         stable_q  <= '0;
         gpioin_q  <= {PARITYSEL ^ FORCE_ERR, {WIDTH{1'b0}}};
         changed_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         gpioin_q  <= gpioin_d;
         changed_q <= changed_d;
      end
   end

   assign GPIOIN  = gpioin_q;
   assign CHANGED = changed_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Testbench for gpio_in_cond: directed vector table, hand-written latency/reset/toggle
// sequences, and random stimulus compared every cycle against a sliding-window model.
module tb_gpio_in_cond;

   localparam int W  = 16;
   localparam int SS = 2;
   localparam int DC = 4;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic [W-1:0]  PAD_IN;
   logic          PARITYSEL;
   logic          FORCE_ERR;
   logic [W:0]    GPIOIN;
   logic          CHANGED;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   gpio_in_cond #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .PAD_IN    (PAD_IN),
      .PARITYSEL (PARITYSEL),
      .FORCE_ERR (FORCE_ERR),
      .GPIOIN    (GPIOIN),
      .CHANGED   (CHANGED)
   );

   always #5 HCLK = ~HCLK;

   // Reference model: a bit is accepted once the last DC synchronised samples
   // all disagree with its accepted value. Synchronisation is a plain delay line.
   logic [W-1:0] pad_hist[$];
   logic [W-1:0] sync_hist[$];
   logic [W-1:0] m_stable;
   logic [W:0]   m_gpio;
   logic         m_chg;
   bit           m_valid = 1'b0;

   always @(posedge HCLK) begin
      logic [W-1:0] s, nxt;
      logic         p;
      int           ones;
      bit           all_diff;
      if (HRESET) begin
         pad_hist  = {};
         sync_hist = {};
         for (int k = 0; k < SS; k++) pad_hist.push_front('0);
         for (int k = 0; k < DC; k++) sync_hist.push_front('0);
         m_stable = '0;
         m_chg    = 1'b0;
         m_gpio   = {PARITYSEL ^ FORCE_ERR, {W{1'b0}}};
         m_valid  = 1'b1;
      end else if (m_valid) begin
         s = pad_hist[SS-1];
         sync_hist.push_front(s);
         void'(sync_hist.pop_back());
         pad_hist.push_front(PAD_IN);
         void'(pad_hist.pop_back());
         nxt = m_stable;
         for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++)
               if (sync_hist[j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nxt[b] = ~m_stable[b];
         end
         ones = $countones(nxt);
         p = PARITYSEL ? ((ones % 2) == 0) : ((ones % 2) == 1);
         m_chg    = (nxt != m_stable);
         m_stable = nxt;
         m_gpio   = {p ^ FORCE_ERR, nxt};
      end
   end

   always @(negedge HCLK) begin
      if (chk_en) begin
         n_assert++;
         if (GPIOIN !== m_gpio) begin
            n_fail++;
            $display("FAIL model_gpioin @%0t: got %h expected %h", $time, GPIOIN, m_gpio);
         end
         n_assert++;
         if (CHANGED !== m_chg) begin
            n_fail++;
            $display("FAIL model_changed @%0t: got %b expected %b", $time, CHANGED, m_chg);
         end
      end
   end

   task automatic check_val(input string name, input logic [W:0] got, input logic [W:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   typedef struct {
      logic         rst;
      logic [W-1:0] pad;
      logic         psel;
      logic         ferr;
      int           ncyc;
      logic [W:0]   exp_gpio;
      int           exp_chg;
   } vec_t;

   vec_t vecs[18];

   initial begin
      int chg;
      HRESET    = 1'b1;
      PAD_IN    = '0;
      PARITYSEL = 1'b1;
      FORCE_ERR = 1'b0;

      vecs[0]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 2, 17'h10000, 0};
      vecs[1]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 2, 17'h00000, 0};
      vecs[2]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 2, 17'h10000, 0};
      vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3, 17'h10000, 0};
      vecs[4]  = '{1'b0, 16'h0008, 1'b1, 1'b0, 3, 17'h10000, 0};
      vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8, 17'h10000, 0};
      vecs[6]  = '{1'b0, 16'h0008, 1'b1, 1'b0, 4, 17'h10000, 0};
      vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 2, 17'h00008, 1};
      vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8, 17'h10000, 1};
      vecs[9]  = '{1'b0, 16'hA5A5, 1'b1, 1'b0, 8, 17'h1A5A5, 1};
      vecs[10] = '{1'b0, 16'h0003, 1'b1, 1'b0, 8, 17'h10003, 1};
      vecs[11] = '{1'b0, 16'h0003, 1'b0, 1'b0, 1, 17'h00003, 0};
      vecs[12] = '{1'b0, 16'h0003, 1'b0, 1'b1, 1, 17'h10003, 0};
      vecs[13] = '{1'b0, 16'h0003, 1'b1, 1'b0, 1, 17'h10003, 0};
      vecs[14] = '{1'b1, 16'h0000, 1'b1, 1'b0, 2, 17'h10000, 0};
      vecs[15] = '{1'b0, 16'h0001, 1'b1, 1'b0, 5, 17'h10000, 0};
      vecs[16] = '{1'b0, 16'h0001, 1'b0, 1'b0, 1, 17'h10001, 1};
      vecs[17] = '{1'b1, 16'h0000, 1'b1, 1'b0, 2, 17'h10000, 0};

      for (int v = 0; v < 18; v++) begin
         @(negedge HCLK);
         HRESET    = vecs[v].rst;
         PAD_IN    = vecs[v].pad;
         PARITYSEL = vecs[v].psel;
         FORCE_ERR = vecs[v].ferr;
         chg = 0;
         for (int c = 0; c < vecs[v].ncyc; c++) begin
            @(posedge HCLK);
            #1;
            if (CHANGED === 1'b1) chg++;
         end
         check_val($sformatf("vec%0d_gpioin", v), GPIOIN, vecs[v].exp_gpio);
         check_val($sformatf("vec%0d_changed_count", v), 17'(chg), 17'(vecs[v].exp_chg));
         if (v == 0) chk_en = 1'b1;
      end

      // Exact pad-to-output latency from the reset state, odd mode.
      @(negedge HCLK);
      HRESET = 1'b0;
      PAD_IN = 16'h0001;
      for (int e = 0; e <= 6; e++) begin
         @(posedge HCLK);
         #1;
         check_val($sformatf("lat_e%0d_gpioin", e), GPIOIN, (e < 5) ? 17'h10000 : 17'h00001);
         check_val($sformatf("lat_e%0d_changed", e), {16'h0, CHANGED}, (e == 5) ? 17'h1 : 17'h0);
      end

      // Reset in the middle of a debounce, then release with the pad held.
      @(negedge HCLK);
      HRESET = 1'b1;
      PAD_IN = '0;
      @(negedge HCLK);
      HRESET = 1'b0;
      PAD_IN = 16'h0010;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      HRESET = 1'b1;
      @(posedge HCLK);
      #1;
      check_val("midrst_gpioin", GPIOIN, 17'h10000);
      @(negedge HCLK);
      HRESET = 1'b0;
      for (int e = 0; e <= 5; e++) begin
         @(posedge HCLK);
         #1;
         check_val($sformatf("midrst_e%0d_gpioin", e), GPIOIN, (e < 5) ? 17'h10000 : 17'h00010);
         check_val($sformatf("midrst_e%0d_changed", e), {16'h0, CHANGED}, (e == 5) ? 17'h1 : 17'h0);
      end

      // Pad bit toggling every cycle never gets accepted.
      chg = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge HCLK);
         PAD_IN = PAD_IN ^ 16'h0001;
         @(posedge HCLK);
         #1;
         if (CHANGED === 1'b1) chg++;
      end
      check_val("toggle_gpioin", GPIOIN, 17'h00010);
      check_val("toggle_changed_count", 17'(chg), 17'h0);

      // Random stimulus; the per-cycle model comparison does the checking.
      for (int c = 0; c < 3000; c++) begin
         @(negedge HCLK);
         if ($urandom_range(7) == 0)
            PAD_IN = 16'($urandom);
         else if ($urandom_range(3) == 0)
            PAD_IN = PAD_IN ^ 16'($urandom & $urandom & $urandom);
         if ($urandom_range(31) == 0) PARITYSEL = ~PARITYSEL;
         if ($urandom_range(31) == 0) FORCE_ERR = ~FORCE_ERR;
         HRESET = ($urandom_range(199) == 0);
      end
      @(negedge HCLK);
      HRESET = 1'b0;
      repeat (2) @(negedge HCLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
